spi_fl_cmd_seq: RTL

- Command sequencer directly upstream of the SPI flash master (spi_master_fl). It drives that master's controller interface.
- Accepts one flash transaction at a time from a host over a valid/ready handshake.
- Optionally prefixes the transaction with Write-Enable (WREN) and follows it with Read-Status (RDSR) polling until the flash WIP bit clears.
- Returns read data plus final status and an error flag to the host.

---
 rtl/spi_fl_cmd_seq.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_fl_cmd_seq.sv
// Command sequencer in front of spi_master_fl: optional WREN prefix, main command,
// optional RDSR polling until WIP clears, then a single response strobe to the host.
module spi_fl_cmd_seq #(
  parameter logic [7:0]  WREN_CMD    = 8'h06,
  parameter logic [7:0]  RDSR_CMD    = 8'h05,
  parameter logic [2:0]  CMD_ONLY_CT = 3'b000,
  parameter logic [2:0]  RDSR_CT     = 3'b001,
  parameter logic [9:0]  RDSR_FRAME  = 10'h000,
  parameter int unsigned ACK_TIMEOUT = 8,
  parameter int unsigned POLL_MAX    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_commtype,
  input  logic [6:0]  req_nbits,
  input  logic [9:0]  req_frame,
  input  logic [3:0]  req_dummy,
  input  logic        req_wren,
  input  logic        req_poll,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [7:0]  resp_status,
  output logic        resp_err,
  output logic [31:0] m_data_in,
  output logic [23:0] m_address,
  output logic [7:0]  m_command,
  output logic [2:0]  m_commtype,
  output logic [6:0]  m_ndata_bits,
  output logic [9:0]  m_frame_struct,
  output logic [3:0]  m_dummy_cycles,
  output logic        m_validflag,
  input  logic [31:0] m_data_out,
  input  logic        m_validflag_out,
  input  logic        m_tready
);

  localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, WREN_ISSUE, WREN_WAIT, CMD_ISSUE, CMD_WAIT, POLL_ISSUE, POLL_WAIT, RESP
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [23:0]         addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [2:0]          ct_q, ct_d;
  logic [6:0]          nbits_q, nbits_d;
  logic [9:0]          frame_q, frame_d;
  logic [3:0]          dummy_q, dummy_d;
  logic                poll_q, poll_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic [7:0]          resp_status_q, resp_status_d;
  logic                err_q, err_d;
  logic                vflag_q, vflag_d;
  logic                acked_q, acked_d;
  logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic                done;
  logic                wip;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      ct_q          <= '0;
      nbits_q       <= '0;
      frame_q       <= '0;
      dummy_q       <= '0;
      poll_q        <= 1'b0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
      err_q         <= 1'b0;
      vflag_q       <= 1'b0;
      acked_q       <= 1'b0;
      ack_cnt_q     <= '0;
      poll_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      ct_q          <= ct_d;
      nbits_q       <= nbits_d;
      frame_q       <= frame_d;
      dummy_q       <= dummy_d;
      poll_q        <= poll_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      err_q         <= err_d;
      vflag_q       <= vflag_d;
      acked_q       <= acked_d;
      ack_cnt_q     <= ack_cnt_d;
      poll_cnt_q    <= poll_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    data_d        = data_q;
    ct_d          = ct_q;
    nbits_d       = nbits_q;
    frame_d       = frame_q;
    dummy_d       = dummy_q;
    poll_d        = poll_q;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    err_d         = err_q;
    vflag_d       = 1'b0;
    acked_d       = acked_q;
    ack_cnt_d     = ack_cnt_q;
    poll_cnt_d    = poll_cnt_q;
    done          = 1'b0;
    // status read in the same cycle as the done edge must decide the next poll
    wip           = m_validflag_out ? m_data_out[0] : resp_status_q[0];

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cmd_d         = req_cmd;
          addr_d        = req_addr;
          data_d        = req_data;
          ct_d          = req_commtype;
          nbits_d       = req_nbits;
          frame_d       = req_frame;
          dummy_d       = req_dummy;
          poll_d        = req_poll;
          resp_data_d   = '0;
          resp_status_d = '0;
          err_d         = 1'b0;
          poll_cnt_d    = '0;
          state_d       = req_wren ? WREN_ISSUE : CMD_ISSUE;
        end
      end
      WREN_ISSUE, CMD_ISSUE, POLL_ISSUE: begin
        if (m_tready) begin
          vflag_d   = 1'b1;
          acked_d   = 1'b0;
          ack_cnt_d = '0;
          if (state_q == POLL_ISSUE) begin
            poll_cnt_d = poll_cnt_q + POLL_W'(1);
            state_d    = POLL_WAIT;
          end else if (state_q == CMD_ISSUE) begin
            state_d = CMD_WAIT;
          end else begin
            state_d = WREN_WAIT;
          end
        end
      end
      WREN_WAIT, CMD_WAIT, POLL_WAIT: begin
        if (m_validflag_out && state_q == CMD_WAIT) resp_data_d = m_data_out;
        if (m_validflag_out && state_q == POLL_WAIT) resp_status_d = m_data_out[7:0];
        // phase A: master must drop tready to acknowledge the start pulse
        if (!acked_q) begin
          if (!m_tready) begin
            acked_d = 1'b1;
          end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            ack_cnt_d = ack_cnt_q + ACK_W'(1);
          end
        end else if (m_tready) begin
          done = 1'b1;
        end
        if (done) begin
          if (state_q == WREN_WAIT) begin
            state_d = CMD_ISSUE;
          end else if (state_q == CMD_WAIT) begin
            state_d = poll_q ? POLL_ISSUE : RESP;
          end else if (!wip) begin
            state_d = RESP;
          end else if (poll_cnt_q < POLL_W'(POLL_MAX)) begin
            state_d = POLL_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // master fields follow the phase, so they stay stable from ISSUE through WAIT
  always_comb begin
    m_data_in      = '0;
    m_address      = '0;
    m_command      = '0;
    m_commtype     = '0;
    m_ndata_bits   = '0;
    m_frame_struct = '0;
    m_dummy_cycles = '0;
    case (state_q)
      WREN_ISSUE, WREN_WAIT: begin
        m_command      = WREN_CMD;
        m_commtype     = CMD_ONLY_CT;
        m_frame_struct = RDSR_FRAME;
      end
      CMD_ISSUE, CMD_WAIT: begin
        m_data_in      = data_q;
        m_address      = addr_q;
        m_command      = cmd_q;
        m_commtype     = ct_q;
        m_ndata_bits   = nbits_q;
        m_frame_struct = frame_q;
        m_dummy_cycles = dummy_q;
      end
      POLL_ISSUE, POLL_WAIT: begin
        m_command      = RDSR_CMD;
        m_commtype     = RDSR_CT;
        m_ndata_bits   = 7'd8;
        m_frame_struct = RDSR_FRAME;
      end
      default: ;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_data   = resp_data_q;
  assign resp_status = resp_status_q;
  assign resp_err    = err_q;
  assign m_validflag = vflag_q;

endmodule
